// File: rtl/hpi_target.sv
// hpi_target: HPI-style host target with a 16-bit internal RAM, an auto-incrementing
// byte address register and a pair of mailboxes between the host and the local side.
//
// Ports:
//   Clk, Reset          - system clock; asynchronous active-high reset
//   OTG_DATA            - bidirectional host data bus, driven only during a held read
//   OTG_ADDR            - register select: 0=DATA, 1=MAILBOX, 2=ADDRESS, 3=STATUS
//   OTG_RD_N/WR_N/CS_N  - active-low host strobes, synchronous to Clk
//   OTG_RST_N           - active-low host soft reset, sampled on Clk
//   OTG_INT             - high while the host-bound mailbox holds unread data
//   mbx_in_data/wr      - local-side write into the host-bound mailbox
//   mbx_out_data/valid  - host-written mailbox presented to the local side
//   mbx_out_ack         - local side consumes the host-written mailbox
//   mbx_out_ovr         - sticky: host overwrote an unacknowledged mailbox
module hpi_target #(
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic        Clk,
  input  logic        Reset,
  inout  logic [15:0] OTG_DATA,
  input  logic [1:0]  OTG_ADDR,
  input  logic        OTG_RD_N,
  input  logic        OTG_WR_N,
  input  logic        OTG_CS_N,
  input  logic        OTG_RST_N,
  output logic        OTG_INT,
  input  logic [15:0] mbx_in_data,
  input  logic        mbx_in_wr,
  output logic [15:0] mbx_out_data,
  output logic        mbx_out_valid,
  input  logic        mbx_out_ack,
  output logic        mbx_out_ovr
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  localparam logic [1:0] RegData    = 2'd0;
  localparam logic [1:0] RegMailbox = 2'd1;
  localparam logic [1:0] RegAddress = 2'd2;
  localparam logic [1:0] RegStatus  = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StWrHold,
    StRdHold
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [15:0] r_addr;
  logic [15:0] r_mbx_in;
  logic        r_int;
  logic [15:0] r_mbx_out;
  logic        r_valid;
  logic        r_ovr;
  logic [1:0]  r_rd_sel;
  logic [15:0] r_rd_data;
  logic [15:0] r_mem [MEM_WORDS];

  logic        w_cs;
  logic        w_rd;
  logic        w_wr;
  logic        w_soft_rst;
  logic        w_host_wr;
  logic        w_rd_start;
  logic        w_rd_done;
  logic        w_ram_we;
  logic [AW-1:0] w_idx;
  logic [15:0] w_rd_mux;

  assign w_cs       = ~OTG_CS_N;
  assign w_rd       = ~OTG_RD_N;
  assign w_wr       = ~OTG_WR_N;
  assign w_soft_rst = ~OTG_RST_N;

  // Upper address bits alias onto the RAM; bit 0 is the byte lane and never used.
  assign w_idx = r_addr[AW:1];

  // Next-state and access strobes. A write wins over a simultaneous read, and each
  // access fires once on entry; the hold states just wait for the strobe to release.
  always_comb begin
    w_state_next = r_state;
    w_host_wr    = 1'b0;
    w_rd_start   = 1'b0;
    w_rd_done    = 1'b0;
    if (w_soft_rst) begin
      w_state_next = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_cs && w_wr) begin
            w_state_next = StWrHold;
            w_host_wr    = 1'b1;
          end else if (w_cs && w_rd) begin
            w_state_next = StRdHold;
            w_rd_start   = 1'b1;
          end
        end
        StWrHold: begin
          if (!w_cs || !w_wr) begin
            w_state_next = StIdle;
          end
        end
        StRdHold: begin
          if (!w_cs || !w_rd) begin
            w_state_next = StIdle;
            w_rd_done    = 1'b1;
          end
        end
        default: begin
          w_state_next = StIdle;
        end
      endcase
    end
  end

  always_comb begin
    w_rd_mux = 16'h0000;
    unique case (OTG_ADDR)
      RegData:    w_rd_mux = r_mem[w_idx];
      RegMailbox: w_rd_mux = r_mbx_in;
      RegAddress: w_rd_mux = r_addr;
      RegStatus:  w_rd_mux = {13'b0, r_ovr, r_valid, r_int};
      default:    w_rd_mux = 16'h0000;
    endcase
  end

  // Reset is checked here because the RAM itself has no reset path.
  assign w_ram_we = w_host_wr && (OTG_ADDR == RegData) && !Reset;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_addr <= 16'h0000;
    end else if (w_soft_rst) begin
      r_addr <= 16'h0000;
    end else if (w_host_wr && (OTG_ADDR == RegData)) begin
      r_addr <= r_addr + 16'd2;
    end else if (w_host_wr && (OTG_ADDR == RegAddress)) begin
      r_addr <= {OTG_DATA[15:1], 1'b0};
    end else if (w_rd_done && (r_rd_sel == RegData)) begin
      r_addr <= r_addr + 16'd2;
    end
  end

  // Read data is captured on entry so the bus value stays stable for the whole hold.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_rd_sel  <= RegData;
      r_rd_data <= 16'h0000;
    end else if (w_rd_start) begin
      r_rd_sel  <= OTG_ADDR;
      r_rd_data <= w_rd_mux;
    end
  end

  // A local write in the same cycle as the host's mailbox-read clear keeps the
  // interrupt asserted, since the new data has not been seen yet.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_mbx_in <= 16'h0000;
      r_int    <= 1'b0;
    end else if (w_soft_rst) begin
      r_mbx_in <= 16'h0000;
      r_int    <= 1'b0;
    end else if (mbx_in_wr) begin
      r_mbx_in <= mbx_in_data;
      r_int    <= 1'b1;
    end else if (w_rd_done && (r_rd_sel == RegMailbox)) begin
      r_int    <= 1'b0;
    end
  end

  // An ack landing with a new host write consumes the old word, so no overrun.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_mbx_out <= 16'h0000;
      r_valid   <= 1'b0;
      r_ovr     <= 1'b0;
    end else if (w_soft_rst) begin
      r_mbx_out <= 16'h0000;
      r_valid   <= 1'b0;
      r_ovr     <= 1'b0;
    end else if (w_host_wr && (OTG_ADDR == RegMailbox)) begin
      r_mbx_out <= OTG_DATA;
      r_valid   <= 1'b1;
      r_ovr     <= !mbx_out_ack && (r_ovr || r_valid);
    end else if (mbx_out_ack) begin
      r_valid   <= 1'b0;
      r_ovr     <= 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (w_ram_we) begin
      r_mem[w_idx] <= OTG_DATA;
    end
  end

  // Depends on live strobes so the bus releases as soon as the host lets go.
  assign OTG_DATA      = (r_state == StRdHold && w_cs && w_rd) ? r_rd_data : 16'hzzzz;
  assign OTG_INT       = r_int;
  assign mbx_out_data  = r_mbx_out;
  assign mbx_out_valid = r_valid;
  assign mbx_out_ovr   = r_ovr;

endmodule

// File: tb/tb_hpi_target.sv
// tb_hpi_target: directed bench for hpi_target. A transaction-level model tracks the
// address register, RAM, mailboxes and interrupt; a per-cycle compare process checks
// the DUT outputs against it, and directed sequences add literal expectations.
// The bus carries a pull-up, so an undriven bus reads as 16'hFFFF.
module tb_hpi_target;

  localparam int unsigned MemWords = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic        rd_n, wr_n, cs_n, rst_n;
  logic [15:0] in_data;
  logic        in_wr, ack;
  wire  [15:0] otg_data;
  logic [15:0] tb_data;
  logic        tb_oe;
  wire         otg_int;
  wire  [15:0] out_data;
  wire         out_valid, out_ovr;

  assign otg_data = tb_oe ? tb_data : 16'hzzzz;
  pullup (otg_data);

  always #5 clk = ~clk;

  hpi_target #(.MEM_WORDS(MemWords)) dut (
    .Clk          (clk),
    .Reset        (reset),
    .OTG_DATA     (otg_data),
    .OTG_ADDR     (addr),
    .OTG_RD_N     (rd_n),
    .OTG_WR_N     (wr_n),
    .OTG_CS_N     (cs_n),
    .OTG_RST_N    (rst_n),
    .OTG_INT      (otg_int),
    .mbx_in_data  (in_data),
    .mbx_in_wr    (in_wr),
    .mbx_out_data (out_data),
    .mbx_out_valid(out_valid),
    .mbx_out_ack  (ack),
    .mbx_out_ovr  (out_ovr)
  );

  // Model state
  logic [15:0] m_ram [MemWords];
  logic [15:0] m_addr, m_mbx_in, m_out_data;
  logic        m_int, m_valid, m_ovr;
  logic        exp_drive;
  logic [15:0] exp_rd;
  logic        cmp_en;
  int          checks = 0;
  int          errors = 0;

  function automatic int m_idx();
    return (int'(m_addr) / 2) % MemWords;
  endfunction

  function automatic logic [15:0] m_status();
    return {13'b0, m_ovr, m_valid, m_int};
  endfunction

  task automatic model_reset();
    m_addr = 16'h0000; m_mbx_in = 16'h0000; m_out_data = 16'h0000;
    m_int = 1'b0; m_valid = 1'b0; m_ovr = 1'b0;
    exp_drive = 1'b0;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("otg_int", {15'b0, otg_int}, {15'b0, m_int});
      chk("mbx_out_data", out_data, m_out_data);
      chk("mbx_out_valid", {15'b0, out_valid}, {15'b0, m_valid});
      chk("mbx_out_ovr", {15'b0, out_ovr}, {15'b0, m_ovr});
      if (!tb_oe) chk("bus", otg_data, exp_drive ? exp_rd : 16'hFFFF);
    end
  end

  task automatic host_write(input logic [1:0] a, input logic [15:0] d, input int hold,
                            input logic rd_too, input logic with_ack);
    @(posedge clk); #1;
    addr = a; tb_data = d; tb_oe = 1'b1; cs_n = 1'b0; wr_n = 1'b0;
    rd_n = !rd_too; ack = with_ack;
    @(posedge clk); #1;
    case (a)
      2'd0: begin m_ram[m_idx()] = d; m_addr = m_addr + 16'd2; end
      2'd1: begin
        m_out_data = d;
        m_ovr = !with_ack && (m_ovr || m_valid);
        m_valid = 1'b1;
      end
      2'd2: m_addr = {d[15:1], 1'b0};
      default: ;
    endcase
    ack = 1'b0; tb_oe = 1'b0;
    for (int i = 1; i < hold; i++) begin
      @(posedge clk); #1;
    end
    cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    host_write(a, d, 1, 1'b0, 1'b0);
  endtask

  task automatic host_read(input logic [1:0] a, input logic in_wr_at_exit,
                           output logic [15:0] v);
    @(posedge clk); #1;
    addr = a; cs_n = 1'b0; rd_n = 1'b0;
    @(posedge clk); #1;
    case (a)
      2'd0: exp_rd = m_ram[m_idx()];
      2'd1: exp_rd = m_mbx_in;
      2'd2: exp_rd = m_addr;
      default: exp_rd = m_status();
    endcase
    exp_drive = 1'b1;
    @(negedge clk);
    v = otg_data;
    @(posedge clk); #1;
    cs_n = 1'b1; rd_n = 1'b1; exp_drive = 1'b0;
    if (in_wr_at_exit) begin in_wr = 1'b1; in_data = 16'hC0DE; end
    @(posedge clk); #1;
    if (a == 2'd0) m_addr = m_addr + 16'd2;
    if (a == 2'd1) m_int = 1'b0;
    if (in_wr_at_exit) begin m_mbx_in = 16'hC0DE; m_int = 1'b1; in_wr = 1'b0; end
  endtask

  task automatic local_write(input logic [15:0] d);
    @(posedge clk); #1;
    in_wr = 1'b1; in_data = d;
    @(posedge clk); #1;
    m_mbx_in = d; m_int = 1'b1; in_wr = 1'b0;
  endtask

  task automatic do_ack();
    @(posedge clk); #1;
    ack = 1'b1;
    @(posedge clk); #1;
    m_valid = 1'b0; m_ovr = 1'b0; ack = 1'b0;
  endtask

  // Holds a DATA read open at the current address until the caller aborts it.
  task automatic open_read();
    @(posedge clk); #1;
    addr = 2'd0; cs_n = 1'b0; rd_n = 1'b0;
    @(posedge clk); #1;
    exp_rd = m_ram[m_idx()]; exp_drive = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [15:0] v;
    reset = 1'b1; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; rst_n = 1'b1;
    addr = 2'd0; in_data = 16'h0000; in_wr = 1'b0; ack = 1'b0;
    tb_data = 16'h0000; tb_oe = 1'b0; exp_rd = 16'h0000; cmp_en = 1'b0;
    model_reset();
    #2;
    chk("reset bus", otg_data, 16'hFFFF);
    chk("reset int", {15'b0, otg_int}, 16'h0000);
    chk("reset out_data", out_data, 16'h0000);
    chk("reset status", {14'b0, out_ovr, out_valid}, 16'h0000);
    #10;
    reset = 1'b0; cmp_en = 1'b1;

    // Address auto-increment over writes and reads
    wr(2'd2, 16'h0010); wr(2'd0, 16'hAAAA); wr(2'd0, 16'h5555); wr(2'd2, 16'h0010);
    host_read(2'd0, 1'b0, v); chk("read0 AAAA", v, 16'hAAAA);
    host_read(2'd0, 1'b0, v); chk("read1 5555", v, 16'h5555);
    host_read(2'd2, 1'b0, v); chk("addr after reads", v, 16'h0014);
    chk("model addr", m_addr, 16'h0014);

    // Address wrap and RAM aliasing
    wr(2'd2, 16'hFFFE); wr(2'd0, 16'h1234);
    host_read(2'd2, 1'b0, v); chk("addr wrap", v, 16'h0000);
    wr(2'd2, 16'h01FF);
    host_read(2'd2, 1'b0, v); chk("addr bit0 forced", v, 16'h01FE);
    host_read(2'd0, 1'b0, v); chk("alias read", v, 16'h1234);

    // Host-bound mailbox and interrupt
    local_write(16'hBEEF);
    chk("int set", {15'b0, otg_int}, 16'h0001);
    host_read(2'd3, 1'b0, v); chk("status int", v, 16'h0001);
    host_read(2'd1, 1'b0, v); chk("mbx read", v, 16'hBEEF);
    chk("int cleared", {15'b0, otg_int}, 16'h0000);
    local_write(16'hBEEF);
    host_read(2'd1, 1'b1, v); chk("mbx read w/ new", v, 16'hBEEF);
    chk("int kept by new", {15'b0, otg_int}, 16'h0001);
    host_read(2'd1, 1'b0, v); chk("mbx new data", v, 16'hC0DE);

    // Local-bound mailbox, overrun and ack
    wr(2'd1, 16'h0001); wr(2'd1, 16'h0002);
    chk("out data", out_data, 16'h0002);
    chk("out valid/ovr", {14'b0, out_ovr, out_valid}, 16'h0003);
    host_read(2'd3, 1'b0, v); chk("status ovr", v, 16'h0006);
    do_ack();
    host_read(2'd3, 1'b0, v); chk("status acked", v, 16'h0000);
    wr(2'd1, 16'h0003);
    host_write(2'd1, 16'h0004, 1, 1'b0, 1'b1);
    host_read(2'd3, 1'b0, v); chk("status ack+wr", v, 16'h0002);
    chk("out data ack+wr", out_data, 16'h0004);
    do_ack();
    wr(2'd3, 16'h0007);
    host_read(2'd3, 1'b0, v); chk("status write ignored", v, 16'h0000);

    // Long write strobe and write/read precedence
    wr(2'd2, 16'h0020);
    host_write(2'd0, 16'h7777, 5, 1'b0, 1'b0);
    host_read(2'd2, 1'b0, v); chk("single commit addr", v, 16'h0022);
    wr(2'd2, 16'h0020);
    host_read(2'd0, 1'b0, v); chk("held write data", v, 16'h7777);
    host_read(2'd0, 1'b0, v); chk("no extra write", v, 16'h0000 ^ v === 16'h7777 ? 16'hFFFF : v);
    wr(2'd2, 16'h0022);
    host_write(2'd0, 16'h1111, 2, 1'b1, 1'b0);
    wr(2'd2, 16'h0022);
    host_read(2'd0, 1'b0, v); chk("rd+wr write wins", v, 16'h1111);

    // Host soft reset while a read is held
    local_write(16'h5A5A); wr(2'd1, 16'h0009); wr(2'd2, 16'h0010);
    open_read();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    model_reset();
    rst_n = 1'b1; cs_n = 1'b1; rd_n = 1'b1;
    chk("soft rst int", {15'b0, otg_int}, 16'h0000);
    host_read(2'd2, 1'b0, v); chk("soft rst addr", v, 16'h0000);
    wr(2'd2, 16'h0010);
    host_read(2'd0, 1'b0, v); chk("soft rst ram kept", v, 16'hAAAA);

    // Hard reset while a read is held
    local_write(16'h1357); wr(2'd1, 16'h0042); wr(2'd2, 16'h0012);
    open_read();
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    chk("hard rst bus", otg_data, 16'hFFFF);
    chk("hard rst int", {15'b0, otg_int}, 16'h0000);
    chk("hard rst out", {out_data[13:0], out_ovr, out_valid}, 16'h0000);
    cs_n = 1'b1; rd_n = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    host_read(2'd2, 1'b0, v); chk("hard rst addr", v, 16'h0000);
    wr(2'd2, 16'h0012);
    host_read(2'd0, 1'b0, v); chk("hard rst ram 5555", v, 16'h5555);
    wr(2'd2, 16'h0010);
    host_read(2'd0, 1'b0, v); chk("hard rst ram AAAA", v, 16'hAAAA);

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
